// File: rtl/apb_pkg.sv
// Shared APB bridge definitions: FSM states, default address-map constants,
// the peripheral map used by the software linker script, and a width helper.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;
  localparam int unsigned DEFAULT_SLV_SHIFT = 12;

  // Peripheral windows (4 KB each) as seen by the linker script.
  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] TIMER_BASE = 32'h1000_1000;
  localparam logic [31:0] GPIO_BASE  = 32'h1000_2000;
  localparam logic [31:0] SPI_BASE   = 32'h1000_3000;

  // Index width that stays legal for a single slave.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral decode of a CPU byte address.
// Ports: addr (byte address) -> mapped (address hits a slave window),
//        idx (slave index, valid when mapped).
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned SLV_SHIFT = DEFAULT_SLV_SHIFT,
  localparam int unsigned IDX_W    = idx_width(NUM_SLV)
) (
  input  logic [31:0]      addr,
  output logic             mapped,
  output logic [IDX_W-1:0] idx
);

  logic [31:0] offset;
  logic [31:0] slot;

  assign offset = addr - BASE_ADDR;
  assign slot   = offset >> SLV_SHIFT;

  // Below-base addresses wrap to huge offsets, so check the base explicitly.
  assign mapped = (addr >= BASE_ADDR) && (slot < 32'(NUM_SLV));
  assign idx    = slot[IDX_W-1:0];

endmodule

// File: rtl/apb_master_bridge.sv
// CPU load/store to APB3 master bridge with address decode and timeout.
// Ports: clk/reset (sync, active-high); CPU side transfer/write/addr/wdata in,
//        rdata/ready/err out (ready+err is a one-cycle completion pulse);
//        APB side PADDR/PWDATA/PWRITE/PENABLE/PSEL out, PRDATA/PREADY/PSLVERR
//        in (one lane per slave).
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned SLV_SHIFT = DEFAULT_SLV_SHIFT,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  transfer,
  input  logic                  write,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic                  err,
  output logic [31:0]           PADDR,
  output logic [31:0]           PWDATA,
  output logic                  PWRITE,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int unsigned IDX_W = idx_width(NUM_SLV);
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SLV-1:0]   psel_d;
  logic                 penable_d, pwrite_d, ready_d, err_d;
  logic [31:0]          paddr_d, pwdata_d, rdata_d;

  logic                 dec_mapped;
  logic [IDX_W-1:0]     dec_idx;
  logic [31:0]          prdata_sel;
  logic                 pready_sel, pslverr_sel, expired;

  apb_addr_decoder #(
    .NUM_SLV   (NUM_SLV),
    .BASE_ADDR (BASE_ADDR),
    .SLV_SHIFT (SLV_SHIFT)
  ) u_dec (
    .addr   (addr),
    .mapped (dec_mapped),
    .idx    (dec_idx)
  );

  // Response lane of the latched slave; other lanes are ignored.
  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        prdata_sel  = PRDATA[i*32 +: 32];
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
      end
    end
  end

  // Counter holds the number of completed ACCESS cycles; expiry is the last one.
  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    psel_d    = PSEL;
    penable_d = 1'b0;
    pwrite_d  = PWRITE;
    paddr_d   = PADDR;
    pwdata_d  = PWDATA;
    rdata_d   = rdata;
    ready_d   = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          if (dec_mapped) begin
            state_d  = SETUP;
            idx_d    = dec_idx;
            psel_d   = NUM_SLV'(1) << dec_idx;
            pwrite_d = write;
            paddr_d  = addr;
            pwdata_d = wdata;
          end else begin
            // Unmapped: complete at once with an error; a load returns zero.
            ready_d = 1'b1;
            err_d   = 1'b1;
            if (!write) rdata_d = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        // PREADY takes priority over a simultaneous expiry.
        if (pready_sel) begin
          state_d = IDLE;
          psel_d  = '0;
          ready_d = 1'b1;
          err_d   = pslverr_sel;
          if (!PWRITE) rdata_d = pslverr_sel ? 32'h0 : prdata_sel;
        end else if (expired) begin
          state_d = IDLE;
          psel_d  = '0;
          ready_d = 1'b1;
          err_d   = 1'b1;
          if (!PWRITE) rdata_d = '0;
        end else begin
          penable_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        psel_d  = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      PSEL    <= '0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      PSEL    <= psel_d;
      PENABLE <= penable_d;
      PWRITE  <= pwrite_d;
      PADDR   <= paddr_d;
      PWDATA  <= pwdata_d;
      rdata   <= rdata_d;
      ready   <= ready_d;
      err     <= err_d;
    end
  end

endmodule
